// File: rtl/lfsr_seq_ctrl.sv
// Sequencer for one lfsr bit generator: drives its enable/clear, packs the
// serial bit stream MSB-first into words and hands them out over valid/ready.
module lfsr_seq_ctrl #(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic              clear_req,
  input  logic              abort,
  input  logic [CNT_W-1:0]  num_words,
  output logic              lfsr_enable,
  output logic              lfsr_clear,
  input  logic              lfsr_bit,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              busy,
  output logic              done
);

  localparam int BC_W = $clog2(WORD_W);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, HOLD, DONE} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WORD_W-2:0]   shreg;
  logic [WORD_W-1:0]   shreg_nxt;
  logic [CNT_W-1:0]    remaining;
  logic [BC_W-1:0]     bit_cnt;
  logic                last_bit;

  // Only WORD_W-1 bits are stored; the final bit goes straight into word_out.
  assign shreg_nxt = {shreg, lfsr_bit};
  assign last_bit  = (bit_cnt == BC_LAST);

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (num_words == '0)
              state_nxt = DONE;
            else if (clear_req)
              state_nxt = CLEAR;
            else
              state_nxt = SHIFT;
          end
        end
        CLEAR: state_nxt = SHIFT;
        SHIFT: if (last_bit) state_nxt = HOLD;
        HOLD: begin
          if (word_ready)
            state_nxt = (remaining == CNT_W'(1)) ? DONE : SHIFT;
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs are registered from the next state so they equal decodes of state.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state       <= IDLE;
      shreg       <= '0;
      word_out    <= '0;
      remaining   <= '0;
      bit_cnt     <= '0;
      lfsr_enable <= 1'b0;
      lfsr_clear  <= 1'b0;
      word_valid  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state       <= state_nxt;
      lfsr_enable <= (state_nxt == SHIFT);
      lfsr_clear  <= (state_nxt == CLEAR);
      word_valid  <= (state_nxt == HOLD);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      if (abort) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (start && (num_words != '0)) begin
              remaining <= num_words;
              bit_cnt   <= '0;
            end
          end
          SHIFT: begin
            shreg <= shreg_nxt[WORD_W-2:0];
            if (last_bit) begin
              word_out <= shreg_nxt;
              bit_cnt  <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          HOLD: begin
            if (word_ready)
              remaining <= remaining - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: a random bit stream stands in for the lfsr and
// every word is predicted from the stream position at which the request began.
module tb_lfsr_seq_ctrl;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 16;
  localparam int SLEN   = 4096;

  logic              clk = 1'b0;
  logic              res = 1'b1;
  logic              start = 1'b0;
  logic              clear_req = 1'b0;
  logic              abort = 1'b0;
  logic [CNT_W-1:0]  num_words = '0;
  logic              lfsr_enable;
  logic              lfsr_clear;
  logic              lfsr_bit;
  logic [WORD_W-1:0] word_out;
  logic              word_valid;
  logic              word_ready = 1'b0;
  logic              busy;
  logic              done;

  logic stream [0:SLEN-1];
  int   ptr = 0;
  int   en_cnt = 0;
  int   clr_cnt = 0;
  int   done_cnt = 0;
  int   checks = 0;
  int   errors = 0;

  lfsr_seq_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .res(res), .start(start), .clear_req(clear_req), .abort(abort),
    .num_words(num_words), .lfsr_enable(lfsr_enable), .lfsr_clear(lfsr_clear),
    .lfsr_bit(lfsr_bit), .word_out(word_out), .word_valid(word_valid),
    .word_ready(word_ready), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Stand-in lfsr: one stream position per enabled clock.
  assign lfsr_bit = stream[ptr];
  always @(posedge clk) begin
    if (lfsr_enable) begin
      ptr    <= ptr + 1;
      en_cnt <= en_cnt + 1;
    end
    if (lfsr_clear) clr_cnt <= clr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [WORD_W-1:0] exp_word(input int base);
    logic [WORD_W-1:0] w = '0;
    for (int b = 0; b < WORD_W; b++) w = {w[WORD_W-2:0], stream[base + b]};
    return w;
  endfunction

  // Runs a full request; poke re-issues start with num_words=5 in the first HOLD.
  task automatic do_req(input int n, input bit clr, input int stall, input bit poke);
    int base = ptr;
    int en0 = en_cnt;
    int d0 = done_cnt;
    int cyc;
    logic [WORD_W-1:0] held;
    num_words = CNT_W'(n);
    clear_req = clr;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (clr) begin
      chk("req_clear_c1", lfsr_clear, 1);
      chk("req_noen_c1", lfsr_enable, 0);
      tick();
    end
    chk("req_enable_first", lfsr_enable, 1);
    for (int w = 0; w < n; w++) begin
      cyc = 0;
      while (!word_valid && cyc < 64) begin
        tick();
        cyc++;
      end
      chk("req_valid_seen", word_valid, 1);
      chk("req_word", word_out, exp_word(base + WORD_W * w));
      chk("req_en_count", en_cnt - en0, WORD_W * (w + 1));
      held = word_out;
      if (poke && w == 0) begin
        start = 1'b1;
        num_words = CNT_W'(5);
        tick();
        start = 1'b0;
        num_words = CNT_W'(n);
        chk("poke_still_hold", word_valid, 1);
      end
      for (int s = 0; s < stall; s++) begin
        tick();
        chk("hold_no_enable", lfsr_enable, 0);
        chk("hold_word_stable", word_out, held);
        chk("hold_valid", word_valid, 1);
      end
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
    end
    chk("req_done_pulse", done, 1);
    chk("req_busy_in_done", busy, 1);
    tick();
    chk("req_busy_low", busy, 0);
    chk("req_done_low", done, 0);
    chk("req_done_count", done_cnt - d0, 1);
    chk("req_en_total", en_cnt - en0, WORD_W * n);
  endtask

  initial begin
    int base;
    int en0;
    int c0;
    int d0;
    logic [7:0] pat;
    for (int i = 0; i < SLEN; i++) stream[i] = 1'($urandom_range(0, 1));

    // Power-on reset
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_enable", lfsr_enable, 0);
    chk("rst_word", word_out, 0);
    res = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Reset mid-SHIFT takes effect without a clock edge
    num_words = CNT_W'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_enable", lfsr_enable, 1);
    res = 1'b1;
    #1;
    chk("async_rst_enable", lfsr_enable, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", word_valid, 0);
    chk("async_rst_clear", lfsr_clear, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_word", word_out, 0);
    tick();
    res = 1'b0;
    tick();
    chk("post_rst_busy", busy, 0);

    // Single word with clear and fixed pattern, exact cycle timing
    base = ptr;
    pat = 8'hB2;
    for (int i = 0; i < 8; i++) stream[base + i] = pat[7 - i];
    c0 = clr_cnt;
    num_words = CNT_W'(1);
    clear_req = 1'b1;
    word_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_req = 1'b0;
    chk("t2_clear_c1", lfsr_clear, 1);
    chk("t2_en_c1", lfsr_enable, 0);
    for (int c = 2; c <= 9; c++) begin
      tick();
      chk("t2_en_shift", lfsr_enable, 1);
      chk("t2_clear_shift", lfsr_clear, 0);
    end
    tick();
    chk("t2_valid_c10", word_valid, 1);
    chk("t2_word_c10", word_out, 8'hB2);
    chk("t2_en_c10", lfsr_enable, 0);
    tick();
    word_ready = 1'b0;
    chk("t2_done_c11", done, 1);
    chk("t2_valid_c11", word_valid, 0);
    tick();
    chk("t2_busy_c12", busy, 0);
    chk("t2_clear_once", clr_cnt - c0, 1);

    // Backpressure
    do_req(3, 1'b0, 5, 1'b0);

    // Randomized requests
    for (int r = 0; r < 4; r++)
      do_req($urandom_range(1, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);

    // Zero-length request
    en0 = en_cnt;
    c0 = clr_cnt;
    num_words = '0;
    clear_req = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_req = 1'b0;
    chk("zero_done_c1", done, 1);
    chk("zero_busy_c1", busy, 1);
    tick();
    chk("zero_busy_c2", busy, 0);
    chk("zero_no_enable", en_cnt - en0, 0);
    chk("zero_no_clear", clr_cnt - c0, 0);

    // Abort after three SHIFT cycles
    base = ptr;
    d0 = done_cnt;
    num_words = CNT_W'(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_en_drop", lfsr_enable, 0);
    chk("abort_no_valid", word_valid, 0);
    chk("abort_no_done", done, 0);
    chk("abort_busy", busy, 0);
    chk("abort_bits_used", ptr - base, 3);
    tick();
    chk("abort_done_count", done_cnt - d0, 0);
    do_req(1, 1'b0, 0, 1'b0);

    // Start while busy is ignored
    do_req(2, 1'b0, 2, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk("poke_no_queue", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
